// File: rtl/stream_stage_if.sv
// Valid/ready stream link: the producer drives valid and payload, the consumer drives ready.
interface std_stream_intf #(
    parameter int DATA_W = 8
);
    logic              valid;
    logic [DATA_W-1:0] payload;
    logic              ready;

    modport in  (input  valid, input  payload, output ready);
    modport out (output valid, output payload, input  ready);
endinterface

// File: rtl/stream_stage.sv
// Chain of STAGES identical stream stages; MODE picks wire tie, forward register or skid buffer.
// Inserted between pipeline blocks to cut valid/payload and/or ready timing paths at full rate.
module stream_stage #(
    parameter int MODE   = 2,
    parameter int STAGES = 1
) (
    input logic         clk,
    input logic         rst,
    std_stream_intf.in  stream_in,
    std_stream_intf.out stream_out
);
    localparam int DATA_W = $bits(stream_in.payload);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_e;

    if ($bits(stream_in.payload) != $bits(stream_out.payload)) begin : g_bad_width
        $error("stream_stage: stream_in and stream_out payload widths differ");
    end
    if (MODE < 0 || MODE > 2) begin : g_bad_mode
        $error("stream_stage: MODE must be 0, 1 or 2");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("stream_stage: STAGES must be in 1..4");
    end

    if (MODE == 0) begin : g_tie
        assign stream_out.valid   = stream_in.valid;
        assign stream_out.payload = stream_in.payload;
        assign stream_in.ready    = stream_out.ready;
    end else begin : g_chain
        // Index k is the link entering stage k; index STAGES is the outgoing link.
        logic [STAGES:0]   vld;
        logic [STAGES:0]   rdy;
        logic [DATA_W-1:0] pl [0:STAGES];

        assign vld[0]             = stream_in.valid;
        assign pl[0]              = stream_in.payload;
        assign stream_in.ready    = rdy[0];
        assign stream_out.valid   = vld[STAGES];
        assign stream_out.payload = pl[STAGES];

        if (MODE == 1) begin : g_fwd_ready
            // Ready ripples combinationally from the sink back through every stage.
            always_comb begin
                rdy[STAGES] = stream_out.ready;
                for (int k = STAGES - 1; k >= 0; k--) begin
                    rdy[k] = !rst && (!vld[k+1] || rdy[k+1]);
                end
            end
        end else begin : g_skid_ready
            assign rdy[STAGES] = stream_out.ready;
        end

        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            if (MODE == 1) begin : g_fwd
                logic              v_q, v_d;
                logic [DATA_W-1:0] d_q, d_d;

                always_comb begin
                    v_d = v_q;
                    d_d = d_q;
                    if (rdy[k]) begin
                        v_d = vld[k];
                        if (vld[k]) d_d = pl[k];
                    end
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        v_q <= 1'b0;
                        d_q <= '0;
                    end else begin
                        v_q <= v_d;
                        d_q <= d_d;
                    end
                end

                assign vld[k+1] = v_q;
                assign pl[k+1]  = d_q;
            end else begin : g_skid
                skid_state_e       state_q, state_d;
                logic [DATA_W-1:0] d_q, d_d;
                logic [DATA_W-1:0] s_q, s_d;
                logic              rdy_q;
                logic              xfer_in, xfer_out;

                assign xfer_in  = vld[k] && rdy_q;
                assign xfer_out = (state_q != EMPTY) && rdy[k+1];

                always_comb begin
                    state_d = state_q;
                    d_d     = d_q;
                    s_d     = s_q;
                    case (state_q)
                        EMPTY: begin
                            if (xfer_in) begin
                                d_d     = pl[k];
                                state_d = ONE;
                            end
                        end
                        ONE: begin
                            if (xfer_in && !xfer_out) begin
                                s_d     = pl[k];
                                state_d = FULL;
                            end else if (xfer_in && xfer_out) begin
                                d_d = pl[k];
                            end else if (xfer_out) begin
                                state_d = EMPTY;
                            end
                        end
                        FULL: begin
                            if (xfer_out) begin
                                d_d     = s_q;
                                state_d = ONE;
                            end
                        end
                        default: state_d = EMPTY;
                    endcase
                end

                // Ready is registered from the next state, so it is already low in FULL.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        state_q <= EMPTY;
                        d_q     <= '0;
                        s_q     <= '0;
                        rdy_q   <= 1'b0;
                    end else begin
                        state_q <= state_d;
                        d_q     <= d_d;
                        s_q     <= s_d;
                        rdy_q   <= (state_d != FULL);
                    end
                end

                assign vld[k+1] = (state_q != EMPTY);
                assign pl[k+1]  = d_q;
                assign rdy[k]   = rdy_q;

                a_no_in_when_full : assert property (@(posedge clk) disable iff (rst)
                    !(state_q == FULL && xfer_in));
            end
        end
    end
endmodule

// File: tb/tb_stream_stage.sv
// Directed bench for stream_stage covering tie, forward and skid configurations side by side.
module tb_stream_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    std_stream_intf #(.DATA_W(16)) a_in (), a_out ();
    std_stream_intf #(.DATA_W(16)) b_in (), b_out ();
    std_stream_intf #(.DATA_W(16)) c_in (), c_out ();
    std_stream_intf #(.DATA_W(16)) d_in (), d_out ();

    stream_stage #(.MODE(0), .STAGES(1)) u_tie  (.clk(clk), .rst(rst), .stream_in(a_in), .stream_out(a_out));
    stream_stage #(.MODE(1), .STAGES(3)) u_fwd3 (.clk(clk), .rst(rst), .stream_in(b_in), .stream_out(b_out));
    stream_stage #(.MODE(2), .STAGES(2)) u_skid (.clk(clk), .rst(rst), .stream_in(c_in), .stream_out(c_out));
    stream_stage #(.MODE(1), .STAGES(1)) u_fwd1 (.clk(clk), .rst(rst), .stream_in(d_in), .stream_out(d_out));

    int n_assert = 0;
    int n_fail   = 0;

    int cyc        = 0;
    int b_nin      = 0;
    int c_nin      = 0;
    int d_nin      = 0;
    int b_first_in = -1;
    logic [15:0] qb [$];
    logic [15:0] qc [$];
    logic [15:0] qd [$];
    int          qb_cyc [$];
    int          qd_cyc [$];
    logic        c_stab_err = 1'b0;
    logic        c_pv = 1'b0;
    logic        c_pr = 1'b0;
    logic [15:0] c_pp = '0;
    int          bad;
    int          qsize0;

    // Transfer monitor: counts accepted inputs, records outputs, and watches skid output stability.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (b_in.valid && b_in.ready) begin
            b_nin <= b_nin + 1;
            if (b_first_in < 0) b_first_in <= cyc;
        end
        if (b_out.valid && b_out.ready) begin
            qb.push_back(b_out.payload);
            qb_cyc.push_back(cyc);
        end
        if (c_in.valid && c_in.ready) c_nin <= c_nin + 1;
        if (c_out.valid && c_out.ready) qc.push_back(c_out.payload);
        if (d_in.valid && d_in.ready) d_nin <= d_nin + 1;
        if (d_out.valid && d_out.ready) begin
            qd.push_back(d_out.payload);
            qd_cyc.push_back(cyc);
        end
        if (!rst && c_pv && !c_pr && (!c_out.valid || c_out.payload !== c_pp)) c_stab_err <= 1'b1;
        c_pv <= c_out.valid;
        c_pr <= c_out.ready;
        c_pp <= c_out.payload;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end of test, expected end within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        a_in.valid = 1'b0; a_in.payload = '0; a_out.ready = 1'b0;
        b_in.valid = 1'b0; b_in.payload = '0; b_out.ready = 1'b1;
        c_in.valid = 1'b0; c_in.payload = '0; c_out.ready = 1'b1;
        d_in.valid = 1'b0; d_in.payload = '0; d_out.ready = 1'b1;

        #1 rst = 1'b1;
        #2;
        check("rst_skid_out_valid", 32'(c_out.valid), 32'd0);
        check("rst_skid_out_payload", 32'(c_out.payload), 32'd0);
        check("rst_skid_in_ready", 32'(c_in.ready), 32'd0);
        check("rst_fwd3_in_ready", 32'(b_in.ready), 32'd0);
        check("rst_fwd3_out_valid", 32'(b_out.valid), 32'd0);
        check("rst_fwd1_in_ready", 32'(d_in.ready), 32'd0);

        // Tie is stateless, so it must pass straight through even while reset is held.
        a_in.valid = 1'b1; a_in.payload = 16'h00A5; a_out.ready = 1'b1;
        #1;
        check("tie_valid", 32'(a_out.valid), 32'd1);
        check("tie_payload", 32'(a_out.payload), 32'h00A5);
        check("tie_ready_hi", 32'(a_in.ready), 32'd1);
        a_out.ready = 1'b0;
        #1;
        check("tie_ready_lo", 32'(a_in.ready), 32'd0);
        a_in.valid = 1'b0;
        #1;
        check("tie_valid_lo", 32'(a_out.valid), 32'd0);

        step();
        step();
        rst = 1'b0;
        #1;
        check("rel_fwd3_ready_now", 32'(b_in.ready), 32'd1);
        check("rel_fwd1_ready_now", 32'(d_in.ready), 32'd1);
        check("rel_skid_ready_not_yet", 32'(c_in.ready), 32'd0);
        step();
        check("rel_skid_ready_edge", 32'(c_in.ready), 32'd1);

        // Forward x3: stream 0..99 into an always-ready sink.
        for (int i = 0; i < 300 && qb.size() < 100; i++) begin
            b_in.valid   = (b_nin < 100);
            b_in.payload = 16'(b_nin);
            step();
        end
        b_in.valid = 1'b0;
        check("fwd3_count", 32'(qb.size()), 32'd100);
        check("fwd3_latency", (qb.size() > 0) ? 32'(qb_cyc[0] - b_first_in) : 32'hFFFF_FFFF, 32'd3);
        check("fwd3_no_gaps", (qb.size() >= 100) ? 32'(qb_cyc[99] - qb_cyc[0]) : 32'hFFFF_FFFF, 32'd99);
        bad = 0;
        foreach (qb[i]) if (qb[i] !== 16'(i)) bad++;
        check("fwd3_order", 32'(bad), 32'd0);

        // Skid x2: stalled sink with an always-valid source fills exactly four slots.
        c_out.ready = 1'b0;
        c_in.valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            c_in.payload = 16'(c_nin);
            step();
        end
        check("skid_stall_accepted", 32'(c_nin), 32'd4);
        check("skid_stall_in_ready", 32'(c_in.ready), 32'd0);
        check("skid_stall_out_valid", 32'(c_out.valid), 32'd1);
        check("skid_stall_out_payload", 32'(c_out.payload), 32'd0);
        c_out.ready = 1'b1;
        for (int i = 0; i < 40 && c_nin < 12; i++) begin
            c_in.payload = 16'(c_nin);
            step();
        end
        c_in.valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("skid_stall_count", 32'(qc.size()), 32'd12);
        bad = 0;
        foreach (qc[i]) if (qc[i] !== 16'(i)) bad++;
        check("skid_stall_order", 32'(bad), 32'd0);

        // Skid x2: random valid and ready, 500 more words.
        for (int i = 0; i < 20000 && c_nin < 512; i++) begin
            c_in.valid   = 1'($urandom_range(0, 1));
            c_in.payload = 16'(c_nin);
            c_out.ready  = 1'($urandom_range(0, 1));
            step();
        end
        c_in.valid  = 1'b0;
        c_out.ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("skid_rand_count", 32'(qc.size()), 32'd512);
        bad = 0;
        foreach (qc[i]) if (qc[i] !== 16'(i)) bad++;
        check("skid_rand_order", 32'(bad), 32'd0);
        check("skid_stable_while_stalled", 32'(c_stab_err), 32'd0);

        // Skid x2: reset with three words buffered.
        c_out.ready = 1'b0;
        c_in.valid  = 1'b1;
        for (int i = 0; i < 10 && c_nin < 515; i++) begin
            c_in.payload = 16'(c_nin);
            step();
        end
        c_in.valid = 1'b0;
        check("skid_buffered_valid", 32'(c_out.valid), 32'd1);
        rst = 1'b1;
        #1;
        check("skid_midrst_out_valid", 32'(c_out.valid), 32'd0);
        check("skid_midrst_in_ready", 32'(c_in.ready), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("skid_postrst_ready_now", 32'(c_in.ready), 32'd0);
        step();
        check("skid_postrst_ready_edge", 32'(c_in.ready), 32'd1);
        qsize0       = qc.size();
        c_in.valid   = 1'b1;
        c_in.payload = 16'hBEEF;
        c_out.ready  = 1'b1;
        step();
        c_in.valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("skid_postrst_count", 32'(qc.size() - qsize0), 32'd1);
        check("skid_postrst_word", (qc.size() > qsize0) ? 32'(qc[qsize0]) : 32'hFFFF_FFFF, 32'h0000BEEF);

        // Forward x1: alternating sink ready, always-valid source, 20 cycles.
        d_in.valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            d_out.ready  = (i % 2 == 0);
            d_in.payload = 16'(d_nin);
            step();
        end
        d_in.valid  = 1'b0;
        d_out.ready = 1'b0;
        check("fwd1_alt_accepted", 32'(d_nin), 32'd10);
        check("fwd1_alt_delivered", 32'(qd.size()), 32'd9);
        check("fwd1_alt_spacing", (qd.size() >= 2) ? 32'(qd_cyc[1] - qd_cyc[0]) : 32'hFFFF_FFFF, 32'd2);
        bad = 0;
        foreach (qd[i]) if (qd[i] !== 16'(i)) bad++;
        check("fwd1_alt_order", 32'(bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
